traffic_light_ctrl: RTL and testbench

- Traffic-light sequencer for a two-road intersection (NS and EW), with a latched pedestrian-walk request.
- Sits directly downstream of the clock divider. Consumes one of its slow divided outputs as a timing tick.
- Everything is clocked on the fast system clock. The tick is treated as data and rising-edge detected, never used as a clock.
- Drives the lamp outputs and exposes phase state and countdown for display and debug.

---
 rtl/traffic_light_ctrl_if.sv | 25 ++
 rtl/traffic_light_ctrl.sv | 123 ++++++++++++
 tb/tb_traffic_light_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the traffic-light sequencer and its environment.
// master: the environment (drives tick and the pedestrian button, reads lamps).
// slave:  the sequencer itself.
interface traffic_light_ctrl_if #(
    parameter int CW = 8
);
    logic          tick;
    logic          ped_req;
    logic [2:0]    ns_light;
    logic [2:0]    ew_light;
    logic          walk;
    logic [2:0]    phase;
    logic [CW-1:0] remaining;
    logic          ped_pending;

    modport master (
        output tick, ped_req,
        input  ns_light, ew_light, walk, phase, remaining, ped_pending
    );

    modport slave (
        input  tick, ped_req,
        output ns_light, ew_light, walk, phase, remaining, ped_pending
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light sequencer with a latched pedestrian-walk request.
// The slow divided tick is sampled as data on clk and rising-edge detected;
// each phase lasts exactly T_x tick edges. Lamps are registered Moore outputs.
module traffic_light_ctrl #(
    parameter int CW       = 8,
    parameter int T_GREEN  = 20,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 1,
    parameter int T_WALK   = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    traffic_light_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5,
        WALK_A    = 3'd6,
        WALK_B    = 3'd7
    } phase_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    phase_t        state, state_nxt;
    logic [CW-1:0] rem, rem_nxt;
    logic          tick_q;
    logic          tick_rise;
    logic          ped_q, ped_nxt;
    logic          in_walk, enter_walk;
    logic [2:0]    ns_q, ew_q, ns_nxt, ew_nxt;
    logic          walk_q, walk_nxt;

    // Countdown reload value for the phase being entered.
    function automatic logic [CW-1:0] load_of(input phase_t p);
        case (p)
            NS_GREEN, EW_GREEN:   load_of = CW'(T_GREEN - 1);
            NS_YELLOW, EW_YELLOW: load_of = CW'(T_YELLOW - 1);
            ALL_RED_A, ALL_RED_B: load_of = CW'(T_ALLRED - 1);
            default:              load_of = CW'(T_WALK - 1);
        endcase
    endfunction

    assign tick_rise = bus.tick & ~tick_q;

    // Next phase, countdown and pedestrian latch from the current state.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        if (tick_rise) begin
            if (rem == '0) begin
                case (state)
                    NS_GREEN:  state_nxt = NS_YELLOW;
                    NS_YELLOW: state_nxt = ALL_RED_A;
                    ALL_RED_A: state_nxt = ped_q ? WALK_A : EW_GREEN;
                    EW_GREEN:  state_nxt = EW_YELLOW;
                    EW_YELLOW: state_nxt = ALL_RED_B;
                    ALL_RED_B: state_nxt = ped_q ? WALK_B : NS_GREEN;
                    WALK_A:    state_nxt = EW_GREEN;
                    default:   state_nxt = NS_GREEN;
                endcase
                rem_nxt = load_of(state_nxt);
            end else begin
                rem_nxt = rem - CW'(1);
            end
        end

        in_walk    = (state == WALK_A) || (state == WALK_B);
        enter_walk = ((state_nxt == WALK_A) || (state_nxt == WALK_B)) && !in_walk;
        // Clearing on walk entry takes priority over a button press that cycle.
        ped_nxt    = enter_walk ? 1'b0 : (ped_q | (bus.ped_req & ~in_walk));
    end

    // Lamp decode of the next phase so the registered lamps track the phase register.
    always_comb begin
        ns_nxt   = LAMP_RED;
        ew_nxt   = LAMP_RED;
        walk_nxt = 1'b0;
        case (state_nxt)
            NS_GREEN:       ns_nxt   = LAMP_GREEN;
            NS_YELLOW:      ns_nxt   = LAMP_YELLOW;
            EW_GREEN:       ew_nxt   = LAMP_GREEN;
            EW_YELLOW:      ew_nxt   = LAMP_YELLOW;
            WALK_A, WALK_B: walk_nxt = 1'b1;
            default:        ;
        endcase
    end

    // State register: reset aborts any phase straight into all-red clearance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ALL_RED_B;
            rem    <= CW'(T_ALLRED - 1);
            tick_q <= 1'b0;
            ped_q  <= 1'b0;
            ns_q   <= LAMP_RED;
            ew_q   <= LAMP_RED;
            walk_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            rem    <= rem_nxt;
            tick_q <= bus.tick;
            ped_q  <= ped_nxt;
            ns_q   <= ns_nxt;
            ew_q   <= ew_nxt;
            walk_q <= walk_nxt;
        end
    end

    assign bus.phase       = state;
    assign bus.remaining   = rem;
    assign bus.ped_pending = ped_q;
    assign bus.ns_light    = ns_q;
    assign bus.ew_light    = ew_q;
    assign bus.walk        = walk_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed tick/button stimulus, an elapsed-time
// reference model checked every cycle, and hand-computed phase tables.
module tb_traffic_light_ctrl;

    localparam int CW = 8;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    traffic_light_ctrl_if #(.CW(CW)) bus();

    traffic_light_ctrl #(
        .CW(CW), .T_GREEN(4), .T_YELLOW(2), .T_ALLRED(1), .T_WALK(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int dur(input int p);
        case (p)
            0, 3:    dur = 4;
            1, 4:    dur = 2;
            2, 5:    dur = 1;
            default: dur = 3;
        endcase
    endfunction

    function automatic int succ(input int p, input bit ped);
        case (p)
            2:       succ = ped ? 6 : 3;
            5:       succ = ped ? 7 : 0;
            6:       succ = 3;
            7:       succ = 0;
            default: succ = p + 1;
        endcase
    endfunction

    int m_ph, m_el, nxt;
    bit m_ped, m_tq, m_valid = 0, rise;

    always @(posedge clk) begin
        if (reset) begin
            m_ph = 5; m_el = 0; m_ped = 0; m_tq = 0; m_valid = 1;
        end else if (m_valid) begin
            rise = bus.tick && !m_tq;
            m_tq = bus.tick;
            nxt  = m_ph;
            if (rise) begin
                if (m_el + 1 == dur(m_ph)) begin
                    nxt  = succ(m_ph, m_ped);
                    m_el = 0;
                end else begin
                    m_el++;
                end
            end
            if ((nxt == 6 || nxt == 7) && nxt != m_ph) m_ped = 0;
            else if (bus.ped_req && m_ph != 6 && m_ph != 7) m_ped = 1;
            m_ph = nxt;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [2:0] e_ns, e_ew;
    logic [18:0] e_vec, a_vec;
    always @(negedge clk) begin
        if (m_valid) begin
            e_ns = (m_ph == 0) ? 3'b001 : (m_ph == 1) ? 3'b010 : 3'b100;
            e_ew = (m_ph == 3) ? 3'b001 : (m_ph == 4) ? 3'b010 : 3'b100;
            e_vec = {3'(m_ph), 8'(dur(m_ph) - 1 - m_el), e_ns, e_ew,
                     (m_ph >= 6) ? 1'b1 : 1'b0, m_ped};
            a_vec = {bus.phase, bus.remaining, bus.ns_light, bus.ew_light,
                     bus.walk, bus.ped_pending};
            checks++;
            if (a_vec !== e_vec) begin
                errors++;
                $display("FAIL model t=%0t got {ph,rem,ns,ew,walk,ped}=%h/%0d/%b/%b/%b/%b want %h/%0d/%b/%b/%b/%b",
                         $time, a_vec[18:16], a_vec[15:8], a_vec[7:5], a_vec[4:2], a_vec[1], a_vec[0],
                         e_vec[18:16], e_vec[15:8], e_vec[7:5], e_vec[4:2], e_vec[1], e_vec[0]);
            end
            checks++;
            if (bus.ns_light != 3'b100 && bus.ew_light != 3'b100) begin
                errors++;
                $display("FAIL safety t=%0t ns=%b ew=%b want one road red", $time,
                         bus.ns_light, bus.ew_light);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse();
        bus.tick = 1'b1;
        repeat (2) step();
        bus.tick = 1'b0;
        repeat (2) step();
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, exp);
        end
    endtask

    // Hand-computed phase/remaining after each tick pulse.
    int ph_a[15]  = '{0,0,0,0,1,1,2,3,3,3,3,4,4,5,0};
    int rem_a[15] = '{3,2,1,0,1,0,0,3,2,1,0,1,0,0,3};
    int ph_b[17]  = '{0,0,0,1,1,2,6,6,6,3,3,3,3,4,4,5,0};
    int rem_b[17] = '{2,1,0,1,0,0,2,1,0,3,2,1,0,1,0,0,3};

    initial begin
        reset = 1'b1;
        bus.tick = 1'b0;
        bus.ped_req = 1'b0;
        repeat (3) step();
        chk("reset_phase", 32'(bus.phase), 5);
        chk("reset_rem", 32'(bus.remaining), 0);
        chk("reset_ped", 32'(bus.ped_pending), 0);
        chk("reset_ns", 32'(bus.ns_light), 4);
        chk("reset_ew", 32'(bus.ew_light), 4);
        chk("reset_walk", 32'(bus.walk), 0);
        reset = 1'b0;

        // Free run, no pedestrian.
        for (int i = 0; i < 15; i++) begin
            pulse();
            chk($sformatf("run_phase[%0d]", i), 32'(bus.phase), 32'(ph_a[i]));
            chk($sformatf("run_rem[%0d]", i), 32'(bus.remaining), 32'(rem_a[i]));
        end

        // Single-cycle button during NS_GREEN.
        bus.ped_req = 1'b1;
        step();
        bus.ped_req = 1'b0;
        step();
        chk("ped_latched", 32'(bus.ped_pending), 1);
        for (int i = 0; i < 17; i++) begin
            pulse();
            chk($sformatf("ped_phase[%0d]", i), 32'(bus.phase), 32'(ph_b[i]));
            chk($sformatf("ped_rem[%0d]", i), 32'(bus.remaining), 32'(rem_b[i]));
            if (i == 6) chk("walk_on", 32'(bus.walk), 1);
            if (i == 6) chk("ped_cleared", 32'(bus.ped_pending), 0);
        end

        // Tick held high for 20 clk counts once.
        bus.tick = 1'b1;
        repeat (20) step();
        bus.tick = 1'b0;
        repeat (2) step();
        chk("held_phase", 32'(bus.phase), 0);
        chk("held_rem", 32'(bus.remaining), 2);

        // Advance to ALL_RED_A with a pending request, then press on the entry edge.
        repeat (5) pulse();
        chk("allred_a", 32'(bus.phase), 2);
        bus.ped_req = 1'b1;
        step();
        bus.ped_req = 1'b0;
        step();
        bus.tick = 1'b1;
        bus.ped_req = 1'b1;
        step();
        bus.ped_req = 1'b0;
        chk("entry_phase", 32'(bus.phase), 6);
        chk("entry_ped", 32'(bus.ped_pending), 0);
        step();
        bus.tick = 1'b0;
        repeat (2) step();
        repeat (3) pulse();
        chk("walk_exit", 32'(bus.phase), 3);
        chk("walk_exit_rem", 32'(bus.remaining), 3);

        // Reset in EW_GREEN with a pending request.
        pulse();
        bus.ped_req = 1'b1;
        step();
        bus.ped_req = 1'b0;
        step();
        chk("pre_rst_rem", 32'(bus.remaining), 2);
        chk("pre_rst_ped", 32'(bus.ped_pending), 1);
        reset = 1'b1;
        step();
        chk("mid_rst_phase", 32'(bus.phase), 5);
        chk("mid_rst_rem", 32'(bus.remaining), 0);
        chk("mid_rst_ped", 32'(bus.ped_pending), 0);
        chk("mid_rst_ns", 32'(bus.ns_light), 4);
        reset = 1'b0;

        // Button held: every all-red leads into a walk.
        bus.ped_req = 1'b1;
        step();
        pulse();
        chk("hold_walk_b", 32'(bus.phase), 7);
        repeat (3) pulse();
        chk("hold_exit_b", 32'(bus.phase), 0);
        chk("hold_reset_ped", 32'(bus.ped_pending), 1);
        repeat (7) pulse();
        chk("hold_walk_a", 32'(bus.phase), 6);
        repeat (3) pulse();
        chk("hold_exit_a", 32'(bus.phase), 3);
        repeat (10) pulse();
        bus.ped_req = 1'b0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
